// File: rtl/pad_in_filter_pkg.sv
// pad_in_filter_pkg: shared default sizes for the pad input filter
//   WIDTH_DEF : default number of pad input lanes
//   CNT_W_DEF : default width of the per-lane filter counter and filter length
package pad_in_filter_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/pad_in_filter_lane.sv
// pad_in_filter_lane: one pad lane - 2-flop synchroniser, glitch filter, edge detect
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   pad_i         : raw asynchronous pad value
//   en_i, len_i   : filter enable and required stable sample count
//   data_o        : filtered value; rise_o/fall_o one-cycle edge pulses
module pad_in_filter_lane
    import pad_in_filter_pkg::*;
#(
    parameter int CntW = CNT_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pad_i,
    input  logic            en_i,
    input  logic [CntW-1:0] len_i,
    output logic            data_o,
    output logic            rise_o,
    output logic            fall_o
);
    localparam logic [CntW-1:0] ONE = 1;
    logic            s1_q, s2_q, data_q, dly_q, mis, data_d;
    logic [CntW-1:0] cnt_q, cnt_d, lim;
    // lim is L-1; disabled filter or zero length behaves as L=1
    always_comb begin
        lim    = (!en_i || len_i == '0) ? '0 : len_i - ONE;
        mis    = s2_q ^ data_q;
        data_d = (mis && cnt_q >= lim) ? s2_q : data_q;
        cnt_d  = (mis && cnt_q < lim) ? cnt_q + ONE : '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            data_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            s1_q   <= pad_i;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            dly_q  <= data_q;
        end
    end
    assign data_o = data_q;
    assign rise_o = data_q & ~dly_q;
    assign fall_o = ~data_q & dly_q;
endmodule

// File: rtl/pad_in_filter.sv
// pad_in_filter: per-lane synchronised glitch filter with sticky edge interrupts
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   pad_in_i                       : raw pad inputs
//   filter_en_i, filter_len_i      : per-lane filter enable, global filter length
//   intr_rise_en_i, intr_fall_en_i : per-lane edge interrupt enables
//   intr_clr_i                     : per-lane interrupt clear pulse
//   data_o, rise_o, fall_o         : filtered value and edge pulses
//   intr_state_o, intr_o           : sticky interrupt status and its OR
module pad_in_filter
    import pad_in_filter_pkg::*;
#(
    parameter int Width = WIDTH_DEF,
    parameter int CntW  = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] pad_in_i,
    input  logic [Width-1:0] filter_en_i,
    input  logic [CntW-1:0]  filter_len_i,
    input  logic [Width-1:0] intr_rise_en_i,
    input  logic [Width-1:0] intr_fall_en_i,
    input  logic [Width-1:0] intr_clr_i,
    output logic [Width-1:0] data_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic [Width-1:0] intr_state_o,
    output logic             intr_o
);
    logic [Width-1:0] intr_state_q, intr_state_d;
    for (genvar i = 0; i < Width; i++) begin : g_lane
        pad_in_filter_lane #(.CntW(CntW)) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .pad_i  (pad_in_i[i]),
            .en_i   (filter_en_i[i]),
            .len_i  (filter_len_i),
            .data_o (data_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i])
        );
    end
    // a new event wins over a simultaneous clear
    always_comb intr_state_d = (rise_o & intr_rise_en_i) | (fall_o & intr_fall_en_i) | (intr_state_q & ~intr_clr_i);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) intr_state_q <= '0;
        else         intr_state_q <= intr_state_d;
    end
    assign intr_state_o = intr_state_q;
    assign intr_o       = |intr_state_q;
endmodule

// File: tb/tb_pad_in_filter.sv
// tb_pad_in_filter: directed self-checking bench for pad_in_filter
module tb_pad_in_filter;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] pad_in_i, filter_en_i, intr_rise_en_i, intr_fall_en_i, intr_clr_i;
    logic [3:0] filter_len_i;
    logic [7:0] data_o, rise_o, fall_o, intr_state_o;
    logic       intr_o;
    int         checks = 0;
    int         failures = 0;

    pad_in_filter #(.Width(8), .CntW(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pad_in_i       (pad_in_i),
        .filter_en_i    (filter_en_i),
        .filter_len_i   (filter_len_i),
        .intr_rise_en_i (intr_rise_en_i),
        .intr_fall_en_i (intr_fall_en_i),
        .intr_clr_i     (intr_clr_i),
        .data_o         (data_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o),
        .intr_state_o   (intr_state_o),
        .intr_o         (intr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        pad_in_i = '0; filter_en_i = '0; filter_len_i = '0;
        intr_rise_en_i = '0; intr_fall_en_i = '0; intr_clr_i = '0;
        step(2);
        chk("rst_data", data_o, 0);
        chk("rst_rise", rise_o, 0);
        chk("rst_fall", fall_o, 0);
        chk("rst_intr_state", intr_state_o, 0);
        chk("rst_intr", intr_o, 0);
        rst_ni = 1'b1;
        step(1);

        // unfiltered lane 0: data on the third edge, rise interrupt
        pad_in_i = 8'h01; intr_rise_en_i = 8'h01;
        step(1); chk("nf_e1_data", data_o, 8'h00);
        step(1); chk("nf_e2_data", data_o, 8'h00);
        step(1); chk("nf_e3_data", data_o, 8'h01);
        chk("nf_e3_rise", rise_o, 8'h01);
        chk("nf_e3_state", intr_state_o, 8'h00);
        step(1); chk("nf_e4_rise", rise_o, 8'h00);
        chk("nf_e4_state", intr_state_o, 8'h01);
        chk("nf_e4_intr", intr_o, 1);
        intr_clr_i = 8'h01;
        step(1); intr_clr_i = 8'h00;
        chk("nf_clr_state", intr_state_o, 8'h00);
        chk("nf_clr_intr", intr_o, 0);
        intr_rise_en_i = 8'h00;

        // lane 2, L=4: 3-cycle glitch rejected, 4-cycle pulse accepted
        filter_en_i = 8'h04; filter_len_i = 4'd4; pad_in_i = 8'h05;
        for (int k = 0; k < 3; k++) begin
            step(1); chk("gl3_data", data_o[2], 0); chk("gl3_rise", rise_o[2], 0);
        end
        pad_in_i = 8'h01;
        for (int k = 0; k < 6; k++) begin
            step(1); chk("gl3_after_data", data_o[2], 0); chk("gl3_after_rise", rise_o[2], 0);
        end
        pad_in_i = 8'h05;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 4) pad_in_i = 8'h01;
            chk("gl4_data", data_o[2], 32'(k == 6));
            chk("gl4_rise", rise_o[2], 32'(k == 6));
        end
        step(1); chk("gl4_rise_end", rise_o[2], 0);
        step(8); chk("gl4_settle", data_o[2], 0);

        // lane 3: length lowered 8 -> 2 while cnt=5
        filter_en_i = 8'h08; filter_len_i = 4'd8; pad_in_i = 8'h09;
        for (int k = 1; k <= 7; k++) begin
            step(1); chk("len8_data", data_o[3], 0);
        end
        filter_len_i = 4'd2;
        step(1); chk("len2_data", data_o[3], 1); chk("len2_rise", rise_o[3], 1);
        pad_in_i = 8'h01;
        step(6); chk("len2_settle", data_o[3], 0);

        // lane 1: clear coincident with fall event loses to the set
        filter_en_i = 8'h00; intr_fall_en_i = 8'h02; pad_in_i = 8'h03;
        step(3); chk("fl_data_hi", data_o, 8'h03);
        pad_in_i = 8'h01;
        step(2); chk("fl_data_still", data_o[1], 1);
        step(1); chk("fl_fall", fall_o, 8'h02); chk("fl_state_pre", intr_state_o, 8'h00);
        intr_clr_i = 8'h02;
        step(1); chk("fl_set_wins", intr_state_o, 8'h02); chk("fl_intr", intr_o, 1);
        chk("fl_fall_end", fall_o, 8'h00);
        step(1); chk("fl_cleared", intr_state_o, 8'h00); chk("fl_intr_off", intr_o, 0);
        intr_clr_i = 8'h00; intr_fall_en_i = 8'h00;

        // lane 4: reset mid-count, pad held high across release
        filter_en_i = 8'h10; filter_len_i = 4'd4; pad_in_i = 8'h11;
        step(4);
        rst_ni = 1'b0; pad_in_i = 8'h10;
        #1;
        chk("mrst_data", data_o, 0);
        chk("mrst_rise", rise_o, 0);
        chk("mrst_fall", fall_o, 0);
        chk("mrst_state", intr_state_o, 0);
        chk("mrst_intr", intr_o, 0);
        step(2); chk("mrst_hold", data_o, 0);
        rst_ni = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("rel_rise", rise_o, (k == 6) ? 8'h10 : 8'h00);
            chk("rel_data", data_o, (k >= 6) ? 8'h10 : 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pad_in_filter.md
PAD_IN_FILTER -- requirements
Module: pad_in_filter

Interface
REQ-001 SHALL have parameter Width, default 8: number of pad input lanes.
REQ-002 SHALL have parameter CntW, default 4: width of the per-lane filter counter and of filter_len_i.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pad_in_i  input  Width  raw, asynchronous pad input values from the pad wrapper input path.
REQ-006 SHALL have port filter_en_i  input  Width  per-lane glitch filter enable.
REQ-007 SHALL have port filter_len_i  input  CntW  consecutive stable samples required before data_o changes (global, all lanes).
REQ-008 SHALL have port intr_rise_en_i  input  Width  per-lane rising-edge interrupt enable.
REQ-009 SHALL have port intr_fall_en_i  input  Width  per-lane falling-edge interrupt enable.
REQ-010 SHALL have port intr_clr_i  input  Width  per-lane single-cycle clear pulse for intr_state_o.
REQ-011 SHALL have port data_o  output  Width  filtered, synchronised pad value.
REQ-012 SHALL have port rise_o  output  Width  one-cycle pulse on a 0->1 transition of data_o.
REQ-013 SHALL have port fall_o  output  Width  one-cycle pulse on a 1->0 transition of data_o.
REQ-014 SHALL have port intr_state_o  output  Width  sticky per-lane interrupt status.
REQ-015 SHALL have port intr_o  output  1  OR-reduction of intr_state_o.

Function
REQ-016 SHALL pass each pad_in_i bit through a two-flop synchroniser (s1, s2) before any other use.
REQ-017 SHALL keep per lane a counter cnt and a data register; a "mismatch" is s2 != data_o.
REQ-018 SHALL define effective length L = 1 when filter_en_i is 0 or filter_len_i is 0; otherwise L = filter_len_i.
REQ-019 SHALL, on mismatch with cnt >= L-1, load data_o from s2 and clear cnt in the same edge.
REQ-020 SHALL, on mismatch with cnt < L-1, increment cnt by 1; on no mismatch, clear cnt to 0.
REQ-021 SHALL therefore update data_o after exactly L consecutive mismatched samples; with L=1 the change appears on data_o on the third rising edge after pad_in_i changes.
REQ-022 SHALL discard glitches shorter than L samples, leaving data_o unchanged and cnt cleared.
REQ-023 SHALL compare cnt with the current L every cycle, so lowering filter_len_i mid-count can complete the update immediately (>= rule) and raising it extends the count; cnt never wraps.
REQ-024 SHALL derive rise_o = data_o & ~data_q and fall_o = ~data_o & data_q combinationally, where data_q is data_o delayed one cycle.
REQ-025 SHALL set intr_state_o[i] on (rise_o[i] & intr_rise_en_i[i]) | (fall_o[i] & intr_fall_en_i[i]); set wins over a simultaneous intr_clr_i[i].
REQ-026 SHALL clear intr_state_o[i] on intr_clr_i[i] when no set occurs in that cycle; clear of an already-0 bit has no effect.
REQ-027 SHALL drive intr_o combinationally as |intr_state_o.

Reset
REQ-028 SHALL asynchronously clear s1, s2, cnt, data_o, data_q and intr_state_o to 0 when rst_ni is low; rise_o, fall_o and intr_o are therefore 0 during reset.
REQ-029 SHALL treat a pad held high across reset release as a normal 0->1 transition, producing one rise_o pulse after L+2 cycles.

Structure
REQ-030 SHALL place default Width and CntW constants in shared package pad_in_filter_pkg.
REQ-031 SHALL implement one lane (synchroniser, counter, data/data_q registers, edge detect) in sub-module pad_in_filter_lane, instantiated Width times; interrupt status and intr_o stay in the top level.

Verification
REQ-032 SHALL cover: filter_en_i=0, pad_in_i[0] 0->1 -> data_o[0]=1 on third edge, rise_o[0] one cycle, intr_state_o[0]=1 if intr_rise_en_i[0]=1.
REQ-033 SHALL cover: filter_en_i=1, filter_len_i=4, 3-cycle high glitch -> data_o unchanged, no rise_o; 4-cycle high -> data_o=1 exactly 4 samples after s2 goes high.
REQ-034 SHALL cover: filter_len_i lowered from 8 to 2 while cnt=5 with mismatch -> data_o updates on the next edge.
REQ-035 SHALL cover: intr_clr_i[1] asserted in the same cycle as a fall_o[1] with intr_fall_en_i[1]=1 -> intr_state_o[1] remains 1; clear next cycle -> 0, intr_o=0.
REQ-036 SHALL cover: rst_ni asserted mid-count (cnt=2) -> all outputs 0 immediately; pad high at release -> single rise_o after L+2 cycles.
